// File: rtl/ncc_stream_corr.sv
// Streaming cross-correlation engine: holds an N x N descriptor patch and, for
// each N x N window patch streamed one row per cycle, produces the integer sum
// of products together with the window sum and window sum of squares.
module ncc_stream_corr #(
  parameter int unsigned N           = 16,
  parameter int unsigned PW          = 8,
  parameter int unsigned LANES       = 4,
  parameter int unsigned SIGNED_DESC = 0,
  parameter int unsigned ACC_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                desc_valid,
  output logic                desc_ready,
  input  logic [LANES*PW-1:0] desc_data,
  input  logic                desc_reload,
  output logic                desc_loaded,
  input  logic                win_valid,
  output logic                win_ready,
  input  logic [N*PW-1:0]     win_row,
  output logic                score_valid,
  input  logic                score_ready,
  output logic [ACC_W-1:0]    score_sum,
  output logic [ACC_W-1:0]    score_win_sum,
  output logic [ACC_W-1:0]    score_win_sq
);

  localparam int unsigned WORDS = (N * N) / LANES;
  localparam int unsigned WCW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned RCW   = $clog2(N);
  localparam int unsigned IW    = $clog2(N * N);
  localparam int unsigned PRW   = 2 * PW + 1;
  localparam int unsigned SQW   = 2 * PW;

  if (N < 2) begin : g_n_chk
    $error("ncc_stream_corr: N must be at least 2");
  end
  if ((N * N) % LANES != 0) begin : g_lane_chk
    $error("ncc_stream_corr: N*N must be a multiple of LANES");
  end
  if (ACC_W < 2 * PW + 1 + 2 * $clog2(N)) begin : g_acc_chk
    $error("ncc_stream_corr: ACC_W too narrow for exact patch sums");
  end

  typedef enum logic [1:0] {
    DLOAD = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t         state;
  logic [WCW-1:0] wcnt;
  logic [RCW-1:0] rcnt;
  logic           fcnt;

  logic [PW-1:0]  desc_mem [N*N];

  logic desc_acc, win_acc, reload_go, desc_last, row_last, load_out;

  // Reload taking effect blocks the same-cycle row so a sender never sees a
  // handshake on a row that the engine then drops.
  assign reload_go   = (state == RUN) && (rcnt == '0) && desc_reload;
  assign desc_ready  = (state == DLOAD);
  assign win_ready   = (state == RUN) && !reload_go;
  assign score_valid = (state == HOLD);
  assign desc_acc    = desc_valid && desc_ready;
  assign win_acc     = win_valid && win_ready;
  assign desc_last   = desc_acc && (wcnt == WCW'(WORDS - 1));
  assign row_last    = win_acc && (rcnt == RCW'(N - 1));
  assign load_out    = (state == FLUSH) && fcnt;

  // Control FSM with descriptor word, window row and flush counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= DLOAD;
      wcnt        <= '0;
      rcnt        <= '0;
      fcnt        <= 1'b0;
      desc_loaded <= 1'b0;
    end else begin
      case (state)
        DLOAD: if (desc_acc) begin
          if (desc_last) begin
            wcnt        <= '0;
            desc_loaded <= 1'b1;
            state       <= RUN;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        RUN: if (reload_go) begin
          desc_loaded <= 1'b0;
          state       <= DLOAD;
        end else if (win_acc) begin
          if (row_last) begin
            fcnt  <= 1'b0;
            state <= FLUSH;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        FLUSH: if (fcnt) begin
          fcnt  <= 1'b0;
          state <= HOLD;
        end else begin
          fcnt <= 1'b1;
        end
        HOLD: if (score_ready) begin
          rcnt  <= '0;
          state <= RUN;
        end
        default: state <= DLOAD;
      endcase
    end
  end

  // Descriptor storage, written lane by lane in raster order (not reset)
  always_ff @(posedge clk) begin
    if (desc_acc) begin
      for (int unsigned l = 0; l < LANES; l++) begin
        desc_mem[IW'(32'(wcnt) * LANES + l)] <= desc_data[(LANES-1-l)*PW +: PW];
      end
    end
  end

  // Stage 0: capture the accepted window row and its descriptor row index
  logic [N*PW-1:0] row_q;
  logic [RCW-1:0]  rsel_q;
  logic            v0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q  <= '0;
      rsel_q <= '0;
      v0     <= 1'b0;
    end else begin
      v0 <= win_acc;
      if (win_acc) begin
        row_q  <= win_row;
        rsel_q <= rcnt;
      end
    end
  end

  logic [PW-1:0]         pix_c   [N];
  logic [PW-1:0]         dsel_c  [N];
  logic signed [PW:0]    d_ext_c [N];
  logic signed [PW:0]    w_ext_c [N];
  logic signed [PRW-1:0] prod_c  [N];
  logic [SQW-1:0]        sq_c    [N];

  // Element-wise products and squares for the captured row
  always_comb begin
    for (int unsigned c = 0; c < N; c++) begin
      pix_c[c]   = row_q[(N-1-c)*PW +: PW];
      dsel_c[c]  = desc_mem[IW'(32'(rsel_q) * N + c)];
      d_ext_c[c] = (SIGNED_DESC != 0) ? {dsel_c[c][PW-1], dsel_c[c]} : {1'b0, dsel_c[c]};
      w_ext_c[c] = {1'b0, pix_c[c]};
      prod_c[c]  = PRW'(d_ext_c[c] * w_ext_c[c]);
      sq_c[c]    = SQW'(pix_c[c] * pix_c[c]);
    end
  end

  logic signed [PRW-1:0] prod_q [N];
  logic [PW-1:0]         pix_q  [N];
  logic [SQW-1:0]        sq_q   [N];
  logic                  v1;

  // Stage 1: register products, pixels and squares
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      for (int unsigned c = 0; c < N; c++) begin
        prod_q[c] <= '0;
        pix_q[c]  <= '0;
        sq_q[c]   <= '0;
      end
    end else begin
      v1 <= v0;
      if (v0) begin
        for (int unsigned c = 0; c < N; c++) begin
          prod_q[c] <= prod_c[c];
          pix_q[c]  <= pix_c[c];
          sq_q[c]   <= sq_c[c];
        end
      end
    end
  end

  logic [ACC_W-1:0] acc_sum, acc_win, acc_sq;
  logic [ACC_W-1:0] row_sum, row_win, row_sq;
  logic [ACC_W-1:0] acc_sum_nx, acc_win_nx, acc_sq_nx;

  // Row reductions and next accumulator values
  always_comb begin
    row_sum = '0;
    row_win = '0;
    row_sq  = '0;
    for (int unsigned c = 0; c < N; c++) begin
      row_sum = row_sum + ACC_W'(prod_q[c]);
      row_win = row_win + ACC_W'(pix_q[c]);
      row_sq  = row_sq + ACC_W'(sq_q[c]);
    end
    acc_sum_nx = v1 ? acc_sum + row_sum : acc_sum;
    acc_win_nx = v1 ? acc_win + row_win : acc_win;
    acc_sq_nx  = v1 ? acc_sq + row_sq : acc_sq;
  end

  // Stage 2: accumulate rows; cleared when a held result is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_sum <= '0;
      acc_win <= '0;
      acc_sq  <= '0;
    end else if ((state == HOLD) && score_ready) begin
      acc_sum <= '0;
      acc_win <= '0;
      acc_sq  <= '0;
    end else begin
      acc_sum <= acc_sum_nx;
      acc_win <= acc_win_nx;
      acc_sq  <= acc_sq_nx;
    end
  end

  // Output registers load the final row's contribution on entry to HOLD
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_sum     <= '0;
      score_win_sum <= '0;
      score_win_sq  <= '0;
    end else if (load_out) begin
      score_sum     <= acc_sum_nx;
      score_win_sum <= acc_win_nx;
      score_win_sq  <= acc_sq_nx;
    end
  end

endmodule

// File: doc/ncc_stream_corr.md
# ncc_stream_corr

Parametrised streaming cross-correlation engine, the next generation of the fixed 16x16 log-domain NCC grid in `vision/`. It stores an N x N descriptor patch loaded over a word stream and accepts window patches one row of N pixels per cycle. For each patch it produces the exact integer sum of products plus the window sum and window sum of squares, so the downstream normaliser can compute NCC without re-reading the window. Valid/ready handshakes on all three streams; optional signed (zero-mean) descriptor mode.

## Interface
- N, 16, patch dimension; patch is N x N pixels; N >= 2
- PW, 8, pixel width in bits
- LANES, 4, descriptor pixels per `desc_data` word; N*N must be a multiple of LANES
- SIGNED_DESC, 0, 1 = descriptor pixels are two's complement; window pixels are always unsigned
- ACC_W, 32, accumulator/output width; elaboration error if ACC_W < 2*PW + 1 + 2*clog2(N)

- clk  in  1  clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- desc_valid  in  1  descriptor word valid
- desc_ready  out  1  engine accepts descriptor word
- desc_data  in  LANES*PW  descriptor pixels, MSB lane = lowest column index
- desc_reload  in  1  single-cycle request to load a new descriptor
- desc_loaded  out  1  full descriptor resident
- win_valid  in  1  window row valid
- win_ready  out  1  engine accepts window row
- win_row  in  N*PW  N window pixels, MSB pixel = column 0
- score_valid  out  1  result valid
- score_ready  in  1  result consumed
- score_sum  out  ACC_W  signed sum of desc*win over patch
- score_win_sum  out  ACC_W  unsigned sum of window pixels
- score_win_sq  out  ACC_W  unsigned sum of squared window pixels

## Operation
- FSM states: DLOAD, RUN, FLUSH, HOLD. Reset state DLOAD.
- DLOAD: desc_ready=1. Each desc_valid&desc_ready beat writes LANES pixels at word counter position (row-major, raster order). After beat N*N/LANES-1: counter to 0, desc_loaded=1, -> RUN.
- RUN: win_ready=1. Each accepted row r (row counter 0..N-1) is multiplied element-wise against descriptor row r. On acceptance of row N-1 -> FLUSH.
- FLUSH: win_ready=0; 2 cycles waiting for pipeline to drain, then -> HOLD.
- HOLD: score_valid=1, outputs stable. score_valid&score_ready -> RUN, accumulators and row counter cleared.
- desc_reload is acted on only in RUN with row counter 0 (no patch in progress): desc_loaded=0, -> DLOAD. In any other state/position it is ignored (not queued).
- Arithmetic: product = desc*win, desc sign-extended when SIGNED_DESC=1, else zero-extended, width 2*PW+1. Per-row sums via adder tree, then added into ACC_W accumulators; overflow wraps modulo 2^ACC_W (cannot occur when ACC_W meets the elaboration check).
- Descriptor storage is not reset; unobservable while desc_loaded=0.
- Async reset at any point: state DLOAD, all counters/accumulators 0, pipeline valids 0, in-flight patch discarded.

## Timing
- Reset values: desc_ready=1, desc_loaded=0, win_ready=0, score_valid=0, score_sum=score_win_sum=score_win_sq=0.
- Pipeline: edge T accepts row; edge T+1 registers products, pixel values, squares; edge T+2 adds row sums into accumulators.
- Latency: last row accepted at edge T -> score_valid high from the cycle after edge T+2.
- Throughput: one row per cycle in RUN; min N+3 cycles per patch (N rows, 2 FLUSH cycles, 1 HOLD cycle).
- Descriptor load: one word per cycle; gaps in desc_valid simply stall the counter.
- win_valid while win_ready=0 is ignored, row not consumed.
- Output registers change only on entry to HOLD or on reset.

## Test plan
- Reset: hold rst_n=0 -> all outputs at listed reset values; release -> desc_ready=1 the next cycle.
- N=4, PW=8, LANES=4, SIGNED_DESC=0: load 4 words 0x01010101, stream 4 rows of all 0x02 -> score_sum=32, win_sum=32, win_sq=64, score_valid 2 cycles after last row.
- SIGNED_DESC=1: descriptor all 0xFF (-1), window all 3 -> score_sum=0xFFFFFFD0 (-48), win_sum=48, win_sq=144.
- Backpressure: hold score_ready=0 for 5 cycles in HOLD with win_valid=1 -> outputs stable, win_ready=0, no row consumed; after handshake next patch result is correct.
- Reload: desc_reload mid-patch ignored (result unchanged); between patches reload 0x02020202 with gapped desc_valid -> next all-0x02 patch gives score_sum=64.
- N=16 defaults, desc and window all 255 -> score_sum=16,646,400; async reset during row 7 -> DLOAD, desc_loaded=0, score_valid never asserted.
